// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// branch_predictor_pkg : shared counter encodings and BTB sizing defaults
// Rev 1.0
// ============================================================================
package branch_predictor_pkg;

  localparam int c_BTB_IDX_W_DEF = 4;
  localparam int c_PC_W          = 32;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// branch_predictor_if : fetch lookup and execute-stage update bundle
// Rev 1.0
// ============================================================================
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [c_PC_W-1:0] fetch_pc_i;
  logic              predict_taken;
  logic              btb_hit;
  logic [c_PC_W-1:0] btb_pre_pc;
  logic              upd_valid_i;
  logic [c_PC_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [c_PC_W-1:0] upd_target_i;
  logic              flush_i;

  modport slave (
    input  fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
    output predict_taken, btb_hit, btb_pre_pc
  );

  modport master (
    output fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
    input  predict_taken, btb_hit, btb_pre_pc
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// sat_counter2 : 2-bit saturating direction counter next-state logic
// Rev 1.0
// ============================================================================
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_e cur,
  input  logic taken,
  output cnt_e next
);

  always_comb begin
    next = cur;
    unique case (cur)
      CNT_SNT: next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  next = taken ? CNT_ST  : CNT_WT;
      default: next = cur;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// branch_predictor : direct-mapped BTB with 2-bit counters, zero-latency lookup
// Rev 1.0
// ============================================================================
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_IDX_W = c_BTB_IDX_W_DEF
) (
  input  wire logic          clk,
  input  wire logic          rst,
  branch_predictor_if.slave  bp
);

  localparam int c_N     = 1 << BTB_IDX_W;
  localparam int c_TAG_W = c_PC_W - BTB_IDX_W - 2;

  logic [c_N-1:0]    valid_q, valid_d;
  cnt_e              cnt_q    [c_N];
  cnt_e              cnt_d    [c_N];
  logic [c_TAG_W-1:0] tag_q   [c_N];
  logic [c_TAG_W-1:0] tag_d   [c_N];
  logic [c_PC_W-1:0] target_q [c_N];
  logic [c_PC_W-1:0] target_d [c_N];

  logic [BTB_IDX_W-1:0] fetch_idx, upd_idx;
  logic [c_TAG_W-1:0]   fetch_tag, upd_tag;
  logic                 fetch_hit, upd_hit;
  cnt_e                 cnt_next;
  logic                 unused_pc_lsbs;

  assign fetch_idx      = bp.fetch_pc_i[BTB_IDX_W+1:2];
  assign fetch_tag      = bp.fetch_pc_i[c_PC_W-1:BTB_IDX_W+2];
  assign upd_idx        = bp.upd_pc_i[BTB_IDX_W+1:2];
  assign upd_tag        = bp.upd_pc_i[c_PC_W-1:BTB_IDX_W+2];
  assign unused_pc_lsbs = ^{bp.fetch_pc_i[1:0], bp.upd_pc_i[1:0]};

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign fetch_hit        = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign bp.btb_hit       = fetch_hit;
  assign bp.predict_taken = fetch_hit && cnt_q[fetch_idx][1];
  assign bp.btb_pre_pc    = fetch_hit ? target_q[fetch_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .cur   (cnt_q[upd_idx]),
    .taken (bp.upd_taken_i),
    .next  (cnt_next)
  );

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bp.flush_i) begin
      valid_d = '0;
    end else if (bp.upd_valid_i) begin
      if (upd_hit) begin
        cnt_d[upd_idx] = cnt_next;
        if (bp.upd_taken_i) begin
          target_d[upd_idx] = bp.upd_target_i;
        end
      end else if (bp.upd_taken_i) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bp.upd_target_i;
        cnt_d[upd_idx]    = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < c_N; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag and target storage carries no reset; entries are qualified by valid.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule
`default_nettype wire
